// File: rtl/rank_order_encoder_pkg.sv
// Shared SNN accelerator constants: image geometry, input word width and encoder FSM states.
package rank_order_encoder_pkg;

  localparam int unsigned IMAGE_SIZE     = 256;
  localparam int unsigned PIXEL_BITS     = 8;
  localparam int unsigned AXI_DATA_WIDTH = 32;

  // FSM state encoding kept as plain constants so older tools can consume it.
  typedef logic [2:0] state_t;

  localparam state_t ST_LOAD   = 3'd0;
  localparam state_t ST_SCAN   = 3'd1;
  localparam state_t ST_REQ_HI = 3'd2;
  localparam state_t ST_REQ_LO = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

endpackage

// File: rtl/rank_order_img_buf.sv
// Image buffer: whole-word writes from the input stream, single-pixel combinational reads
// for the scanner.
module rank_order_img_buf #(
  parameter int unsigned IMAGE_SIZE     = rank_order_encoder_pkg::IMAGE_SIZE,
  parameter int unsigned PIXEL_BITS     = rank_order_encoder_pkg::PIXEL_BITS,
  parameter int unsigned AXI_DATA_WIDTH = rank_order_encoder_pkg::AXI_DATA_WIDTH
) (
  input  logic                                                          clk,
  input  logic                                                          we,
  input  logic [$clog2(IMAGE_SIZE/(AXI_DATA_WIDTH/PIXEL_BITS))-1:0]     waddr,
  input  logic [AXI_DATA_WIDTH-1:0]                                     wdata,
  input  logic [$clog2(IMAGE_SIZE)-1:0]                                 raddr,
  output logic [PIXEL_BITS-1:0]                                         rdata
);

  localparam int unsigned PPW = AXI_DATA_WIDTH / PIXEL_BITS;
  localparam int unsigned SW  = $clog2(PPW);

  logic [PIXEL_BITS-1:0] mem [IMAGE_SIZE];

  // Pixel k of word w lands at address {w, k}.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < int'(PPW); k++) begin
        mem[{waddr, SW'(k)}] <= wdata[k*PIXEL_BITS +: PIXEL_BITS];
      end
    end
  end

  // Combinational read of the pixel under the scan pointer.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/rank_order_encoder.sv
// Rank-order encoder: loads an image from a ready/valid stream, then emits one four-phase AER
// event per non-zero pixel in descending intensity order (ties by ascending address).
module rank_order_encoder #(
  parameter int unsigned IMAGE_SIZE     = rank_order_encoder_pkg::IMAGE_SIZE,
  parameter int unsigned PIXEL_BITS     = rank_order_encoder_pkg::PIXEL_BITS,
  parameter int unsigned AXI_DATA_WIDTH = rank_order_encoder_pkg::AXI_DATA_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [AXI_DATA_WIDTH-1:0]     S_TDATA,
  input  logic                          S_TVALID,
  output logic                          S_TREADY,
  input  logic                          S_TLAST,
  input  logic [$clog2(IMAGE_SIZE)-1:0] EVT_LIMIT,
  output logic [$clog2(IMAGE_SIZE)-1:0] AEROUT_ADDR,
  output logic                          AEROUT_REQ,
  input  logic                          AEROUT_ACK,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          FRAME_ERR
);

  import rank_order_encoder_pkg::*;

  localparam int unsigned PPW   = AXI_DATA_WIDTH / PIXEL_BITS;
  localparam int unsigned WORDS = IMAGE_SIZE / PPW;
  localparam int unsigned AW    = $clog2(IMAGE_SIZE);
  localparam int unsigned WAW   = $clog2(WORDS);

  localparam logic [WAW-1:0]        LAST_WORD = WAW'(WORDS - 1);
  localparam logic [AW-1:0]         LAST_ADDR = AW'(IMAGE_SIZE - 1);
  localparam logic [PIXEL_BITS-1:0] LEVEL_ONE = PIXEL_BITS'(1);
  localparam logic [AW:0]           CNT_ONE   = (AW + 1)'(1);

  state_t                state_q, state_d;
  logic [WAW-1:0]        word_cnt_q, word_cnt_d;
  logic [PIXEL_BITS-1:0] max_q, max_d;
  logic [PIXEL_BITS-1:0] level_q, level_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW:0]           evt_cnt_q, evt_cnt_d;
  logic [AW-1:0]         limit_q, limit_d;
  logic [AW-1:0]         aer_addr_q, aer_addr_d;
  logic                  aer_req_q;
  logic                  frame_err_q, frame_err_d;

  logic                  xfer;
  logic [PIXEL_BITS-1:0] word_max;
  logic [PIXEL_BITS-1:0] new_max;
  logic [PIXEL_BITS-1:0] pix;
  logic [AW-1:0]         adv_addr;
  logic [PIXEL_BITS-1:0] adv_level;
  logic                  adv_done;
  logic [AW:0]           evt_next;

  assign xfer = S_TVALID && (state_q == ST_LOAD);

  rank_order_img_buf #(
    .IMAGE_SIZE     (IMAGE_SIZE),
    .PIXEL_BITS     (PIXEL_BITS),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_img_buf (
    .clk   (CLK),
    .we    (xfer),
    .waddr (word_cnt_q),
    .wdata (S_TDATA),
    .raddr (addr_q),
    .rdata (pix)
  );

  // Largest pixel in the incoming word, folded into the running frame maximum.
  always_comb begin
    word_max = '0;
    for (int k = 0; k < int'(PPW); k++) begin
      if (S_TDATA[k*PIXEL_BITS +: PIXEL_BITS] > word_max) begin
        word_max = S_TDATA[k*PIXEL_BITS +: PIXEL_BITS];
      end
    end
    new_max = (word_max > max_q) ? word_max : max_q;
  end

  // Scan-pointer advance: wrapping the address drops one intensity level; dropping to zero
  // means every non-zero pixel has been visited.
  always_comb begin
    adv_addr  = addr_q + AW'(1);
    adv_level = level_q;
    adv_done  = 1'b0;
    if (addr_q == LAST_ADDR) begin
      adv_addr  = '0;
      adv_level = level_q - LEVEL_ONE;
      adv_done  = (level_q == LEVEL_ONE);
    end
    evt_next = evt_cnt_q + CNT_ONE;
  end

  // Next-state logic for the FSM, counters and max tracker.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    max_d       = max_q;
    level_d     = level_q;
    addr_d      = addr_q;
    evt_cnt_d   = evt_cnt_q;
    limit_d     = limit_q;
    aer_addr_d  = aer_addr_q;
    frame_err_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (S_TLAST && (word_cnt_q == LAST_WORD)) begin
            limit_d    = EVT_LIMIT;
            level_d    = new_max;
            addr_d     = '0;
            word_cnt_d = '0;
            max_d      = '0;
            state_d    = (new_max == '0) ? ST_FINISH : ST_SCAN;
          end else if (S_TLAST || (word_cnt_q == LAST_WORD)) begin
            // Short or unterminated frame: discard and wait for a fresh one.
            frame_err_d = 1'b1;
            word_cnt_d  = '0;
            max_d       = '0;
          end else begin
            word_cnt_d = word_cnt_q + WAW'(1);
            max_d      = new_max;
          end
        end
      end

      ST_SCAN: begin
        if (pix == level_q) begin
          aer_addr_d = addr_q;
          state_d    = ST_REQ_HI;
        end else begin
          addr_d  = adv_addr;
          level_d = adv_level;
          if (adv_done) state_d = ST_FINISH;
        end
      end

      ST_REQ_HI: begin
        if (AEROUT_ACK) state_d = ST_REQ_LO;
      end

      ST_REQ_LO: begin
        if (!AEROUT_ACK) begin
          evt_cnt_d = evt_next;
          if ((limit_q != '0) && (evt_next == {1'b0, limit_q})) begin
            state_d = ST_FINISH;
          end else begin
            addr_d  = adv_addr;
            level_d = adv_level;
            state_d = adv_done ? ST_FINISH : ST_SCAN;
          end
        end
      end

      ST_FINISH: begin
        evt_cnt_d  = '0;
        word_cnt_d = '0;
        max_d      = '0;
        addr_d     = '0;
        level_d    = '0;
        state_d    = ST_LOAD;
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // State registers with synchronous active-low reset; REQ is registered to stay glitch-free.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_LOAD;
      word_cnt_q  <= '0;
      max_q       <= '0;
      level_q     <= '0;
      addr_q      <= '0;
      evt_cnt_q   <= '0;
      limit_q     <= '0;
      aer_addr_q  <= '0;
      aer_req_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      max_q       <= max_d;
      level_q     <= level_d;
      addr_q      <= addr_d;
      evt_cnt_q   <= evt_cnt_d;
      limit_q     <= limit_d;
      aer_addr_q  <= aer_addr_d;
      aer_req_q   <= (state_d == ST_REQ_HI);
      frame_err_q <= frame_err_d;
    end
  end

  // Output decode.
  always_comb begin
    S_TREADY    = (state_q == ST_LOAD);
    BUSY        = (state_q != ST_LOAD);
    DONE        = (state_q == ST_FINISH);
    AEROUT_REQ  = aer_req_q;
    AEROUT_ADDR = aer_addr_q;
    FRAME_ERR   = frame_err_q;
  end

endmodule

// File: tb/tb_rank_order_encoder.sv
// Scoreboard bench for rank_order_encoder: stimulus pushes expected event addresses (and a DONE
// marker) into a queue; a monitor pops and compares as the DUT raises REQ or DONE.
module tb_rank_order_encoder;

  localparam int EXP_DONE = -1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] S_TDATA = '0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic        S_TLAST = 1'b0;
  logic [7:0]  EVT_LIMIT = '0;
  logic [7:0]  AEROUT_ADDR;
  logic        AEROUT_REQ;
  logic        AEROUT_ACK = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        FRAME_ERR;

  always #5 CLK = ~CLK;

  rank_order_encoder dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .S_TDATA     (S_TDATA),
    .S_TVALID    (S_TVALID),
    .S_TREADY    (S_TREADY),
    .S_TLAST     (S_TLAST),
    .EVT_LIMIT   (EVT_LIMIT),
    .AEROUT_ADDR (AEROUT_ADDR),
    .AEROUT_REQ  (AEROUT_REQ),
    .AEROUT_ACK  (AEROUT_ACK),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .FRAME_ERR   (FRAME_ERR)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         sb[$];
  logic [7:0] img [256];
  int         ferr_seen = 0;
  int         ack_delay = 1;
  bit         ack_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every REQ rise and DONE pulse.
  logic       prev_req = 1'b0;
  bit         hs_active = 1'b0;
  logic [7:0] hs_addr = '0;

  always @(negedge CLK) begin
    int exp;
    if (!RST_N) begin
      hs_active = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (FRAME_ERR) ferr_seen++;
      if (AEROUT_REQ && !prev_req) begin
        if (sb.size() == 0) begin
          check("unexpected_event", int'(AEROUT_ADDR), EXP_DONE - 1);
        end else begin
          exp = sb.pop_front();
          check("event_addr", int'(AEROUT_ADDR), exp);
        end
        hs_active = 1'b1;
        hs_addr   = AEROUT_ADDR;
      end else if (hs_active) begin
        check("addr_stable", int'(AEROUT_ADDR), int'(hs_addr));
        if (!AEROUT_REQ && !AEROUT_ACK) hs_active = 1'b0;
      end
      if (DONE) begin
        check("done_expected", int'(DONE), int'(sb.size() != 0 && sb[0] == EXP_DONE));
        if (sb.size() != 0) void'(sb.pop_front());
      end
      prev_req = AEROUT_REQ;
    end
  end

  // AER receiver: answers each phase after ack_delay cycles.
  initial begin
    forever begin
      @(negedge CLK);
      if (ack_en && RST_N) begin
        if (AEROUT_REQ && !AEROUT_ACK) begin
          repeat (ack_delay - 1) @(negedge CLK);
          AEROUT_ACK = 1'b1;
        end else if (!AEROUT_REQ && AEROUT_ACK) begin
          repeat (ack_delay - 1) @(negedge CLK);
          AEROUT_ACK = 1'b0;
        end
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'd0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    while (!S_TREADY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!S_TREADY) check("tready_wait", int'(S_TREADY), 1);
    S_TDATA  = d;
    S_TLAST  = last;
    S_TVALID = 1'b1;
    @(negedge CLK);
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input int last_at);
    for (int w = 0; w < nwords; w++) begin
      send_word({img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]}, (w == last_at));
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int n;
    int ferr0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_req", int'(AEROUT_REQ), 0);
    check("rst_addr", int'(AEROUT_ADDR), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_ferr", int'(FRAME_ERR), 0);
    check("rst_busy", int'(BUSY), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_tready", int'(S_TREADY), 1);

    // Two ties at 200 then a 5; scan walks every level down to 1
    clear_img();
    img[10] = 8'd200;
    img[3]  = 8'd200;
    img[77] = 8'd5;
    EVT_LIMIT = 8'd0;
    sb.push_back(3); sb.push_back(10); sb.push_back(77); sb.push_back(EXP_DONE);
    send_frame(64, 63);
    drain(60000, "t1_drain");
    @(negedge CLK);
    check("t1_tready", int'(S_TREADY), 1);

    // All-zero image: DONE straight after the last word, no events
    clear_img();
    sb.push_back(EXP_DONE);
    send_frame(64, 63);
    n = 0;
    while (!DONE && n < 2) begin
      @(negedge CLK);
      n++;
    end
    check("t2_done_latency", int'(DONE), 1);
    drain(10, "t2_drain");

    // All ones, limit 10
    for (int i = 0; i < 256; i++) img[i] = 8'd1;
    EVT_LIMIT = 8'd10;
    for (int i = 0; i < 10; i++) sb.push_back(i);
    sb.push_back(EXP_DONE);
    send_frame(64, 63);
    drain(2000, "t3_drain");
    @(negedge CLK);
    check("t3_tready", int'(S_TREADY), 1);
    EVT_LIMIT = 8'd0;

    // Early TLAST on word 20, then a good frame
    for (int i = 0; i < 256; i++) img[i] = 8'd7;
    ferr0 = ferr_seen;
    send_frame(21, 20);
    check("t4_ferr_pulse", int'(FRAME_ERR), 1);
    check("t4_busy", int'(BUSY), 0);
    @(negedge CLK);
    check("t4_ferr_count", ferr_seen - ferr0, 1);
    check("t4_ferr_width", int'(FRAME_ERR), 0);
    clear_img();
    img[0]   = 8'd2;
    img[255] = 8'd2;
    img[128] = 8'd1;
    sb.push_back(0); sb.push_back(255); sb.push_back(128); sb.push_back(EXP_DONE);
    send_frame(64, 63);
    drain(2000, "t4_drain");

    // Slow acknowledge: 7 cycles per phase
    ack_delay = 7;
    clear_img();
    img[5]   = 8'd3;
    img[200] = 8'd3;
    img[4]   = 8'd2;
    sb.push_back(5); sb.push_back(200); sb.push_back(4); sb.push_back(EXP_DONE);
    send_frame(64, 63);
    drain(3000, "t5_drain");
    ack_delay = 1;
    repeat (20) @(negedge CLK);

    // Reset while REQ is high and unacknowledged
    ack_en = 1'b0;
    clear_img();
    img[9] = 8'd1;
    sb.push_back(9);
    send_frame(64, 63);
    n = 0;
    while (!AEROUT_REQ && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("t6_req_rise", int'(AEROUT_REQ), 1);
    repeat (3) @(negedge CLK);
    check("t6_req_held", int'(AEROUT_REQ), 1);
    RST_N = 1'b0;
    @(negedge CLK);
    check("t6_req_drop", int'(AEROUT_REQ), 0);
    check("t6_busy", int'(BUSY), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("t6_tready", int'(S_TREADY), 1);
    check("t6_req_low", int'(AEROUT_REQ), 0);
    check("t6_sb_empty", sb.size(), 0);
    ack_en = 1'b1;

    check("ferr_total", ferr_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
